// File: rtl/cordic_ci_pkg.sv
// Shared types and constants for the CORDIC cosine custom-instruction controller.
package cordic_ci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } ci_state_t;

  localparam int          DEFAULT_SETTLE_CYCLES = 4;
  localparam logic [31:0] FP_ONE                = 32'h3F800000;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of the settle window.
module settle_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cordic_ci_controller.sv
// Holds the angle on cos_angle for SETTLE_CYCLES, then samples cos_result and pulses done.
// Optional repeat-angle short-cut enabled by defining CORDIC_RESULT_CACHE_EN.
module cordic_ci_controller
  import cordic_ci_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic [31:0] cos_angle,
  input  logic [31:0] cos_result
);

  ci_state_t   state_q, state_d;
  logic [31:0] angle_q, angle_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        tmr_load, tmr_en, tmr_zero;

`ifdef CORDIC_RESULT_CACHE_EN
  logic [31:0] last_angle_q, last_angle_d;
  logic        cache_valid_q, cache_valid_d;
  logic        hit_q, hit_d;
`endif

  settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (CNT_W'(SETTLE_CYCLES - 1)),
    .en         (tmr_en),
    .zero       (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    result_d = result_q;
    done_d   = done_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
`ifdef CORDIC_RESULT_CACHE_EN
    last_angle_d  = last_angle_q;
    cache_valid_d = cache_valid_q;
    hit_d         = hit_q;
`endif
    // With clk_en low everything holds, including an asserted done.
    if (clk_en) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            angle_d  = dataa;
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
`ifdef CORDIC_RESULT_CACHE_EN
            hit_d = cache_valid_q && (dataa == last_angle_q);
            if (cache_valid_q && (dataa == last_angle_q)) begin
              state_d = ST_CAPTURE;
            end
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          tmr_en = 1'b1;
          if (tmr_zero) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          result_d = cos_result;
          done_d   = 1'b1;
          state_d  = ST_DONE;
`ifdef CORDIC_RESULT_CACHE_EN
          if (hit_q) begin
            result_d = result_q;
          end
          last_angle_d  = angle_q;
          cache_valid_d = 1'b1;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      angle_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

`ifdef CORDIC_RESULT_CACHE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_angle_q  <= '0;
      cache_valid_q <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      last_angle_q  <= last_angle_d;
      cache_valid_q <= cache_valid_d;
      hit_q         <= hit_d;
    end
  end
`endif

  assign cos_angle = angle_q;
  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);

endmodule
